// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load/branch/mult-div stalls and flushes,
// plus the mult/div occupancy FSM that drives HI/LO write-back timing.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       JumpD,
  input  logic       PCSrcD,
  input  logic       MulDivStartE,
  input  logic       DivE,
  input  logic       HiLoUseD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MulDivBusy,
  output logic       HiLoWe
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lwstall, branchstall, mdstall, stall;

  // r0 is hardwired zero, so a match against it never creates a dependency
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic rwm,
                                         input logic [4:0] wrm, input logic rww,
                                         input logic [4:0] wrw);
    if (rwm && hit(wrm, src))      return 2'b10;
    else if (rww && hit(wrw, src)) return 2'b01;
    else                           return 2'b00;
  endfunction

  assign lwstall     = MemtoRegE && (hit(RtE, RsD) || hit(RtE, RtD));
  assign branchstall = BranchD &&
                       ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
                        (MemtoRegM && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));
  assign mdstall     = HiLoUseD && ((state == BUSY) || MulDivStartE);
  assign stall       = lwstall | branchstall | mdstall;

  // reset forces a bubble everywhere and suppresses all forwarding
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      StallF    = stall;
      StallD    = stall;
      FlushE    = stall;
      FlushD    = (PCSrcD | JumpD) & ~stall;
      ForwardAD = RegWriteM && hit(WriteRegM, RsD);
      ForwardBD = RegWriteM && hit(WriteRegM, RtD);
      ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      MulDivBusy <= 1'b0;
      HiLoWe     <= 1'b0;
    end else begin
      MulDivBusy <= 1'b0;
      HiLoWe     <= 1'b0;
      case (state)
        IDLE: if (MulDivStartE) begin
          state      <= BUSY;
          cnt        <= DivE ? DIV_LD : MULT_LD;
          MulDivBusy <= 1'b1;
        end
        // a start pulse arriving while busy is ignored
        BUSY: if (cnt == '0) begin
          state  <= DONE;
          HiLoWe <= 1'b1;
        end else begin
          cnt        <= cnt - CNT_W'(1);
          MulDivBusy <= 1'b1;
        end
        DONE: if (MulDivStartE) begin
          state      <= BUSY;
          cnt        <= DivE ? DIV_LD : MULT_LD;
          MulDivBusy <= 1'b1;
        end else begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load/branch stalls, mult/div timing,
// reset abort and back-to-back starts.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, JumpD, PCSrcD, MulDivStartE, DivE, HiLoUseD;
  logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MulDivBusy, HiLoWe;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .JumpD(JumpD), .PCSrcD(PCSrcD), .MulDivStartE(MulDivStartE), .DivE(DivE),
    .HiLoUseD(HiLoUseD), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MulDivBusy(MulDivBusy),
    .HiLoWe(HiLoWe)
  );

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; JumpD = 0; PCSrcD = 0; MulDivStartE = 0; DivE = 0; HiLoUseD = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    MemtoRegE = 1; RtE = 9; RsD = 9; RegWriteM = 1; WriteRegM = 8; RsE = 8; RtD = 8;
    next_cycle(); next_cycle();
    total++; if (StallF !== 1'b0) $display("FAIL reset_stallf got %b want 0", StallF); else passed++;
    total++; if ({FlushD, FlushE} !== 2'b11) $display("FAIL reset_flush got %b want 11", {FlushD, FlushE}); else passed++;
    total++; if ({ForwardAE, ForwardBD} !== 3'b000) $display("FAIL reset_fwd got %b want 000", {ForwardAE, ForwardBD}); else passed++;
    total++; if ({MulDivBusy, HiLoWe} !== 2'b00) $display("FAIL reset_fsm got %b want 00", {MulDivBusy, HiLoWe}); else passed++;
    clear_inputs();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_forward();
    clear_inputs();
    RegWriteM = 1; WriteRegM = 8; RsE = 8; RegWriteW = 1; WriteRegW = 8; #1;
    total++; if (ForwardAE !== 2'b10) $display("FAIL fwd_m_prio got %b want 10", ForwardAE); else passed++;
    RegWriteM = 0; RtE = 8; #1;
    total++; if ({ForwardAE, ForwardBE} !== 4'b0101) $display("FAIL fwd_w got %b want 0101", {ForwardAE, ForwardBE}); else passed++;
    RegWriteM = 1; WriteRegM = 0; RsE = 0; WriteRegW = 0; RtE = 0; #1;
    total++; if ({ForwardAE, ForwardBE} !== 4'b0000) $display("FAIL fwd_r0 got %b want 0000", {ForwardAE, ForwardBE}); else passed++;
    WriteRegM = 7; RsD = 7; RtD = 6; #1;
    total++; if ({ForwardAD, ForwardBD} !== 2'b10) $display("FAIL fwd_d got %b want 10", {ForwardAD, ForwardBD}); else passed++;
    clear_inputs();
  endtask

  task automatic test_lwstall();
    clear_inputs();
    MemtoRegE = 1; RtE = 9; RsD = 9; PCSrcD = 1; #1;
    total++; if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL lw_stall got %b want 111", {StallF, StallD, FlushE}); else passed++;
    total++; if (FlushD !== 1'b0) $display("FAIL lw_flushd got %b want 0", FlushD); else passed++;
    RsD = 0; RtE = 0; #1;
    total++; if ({StallD, FlushD} !== 2'b01) $display("FAIL lw_r0 got %b want 01", {StallD, FlushD}); else passed++;
    RtE = 4; RtD = 4; MemtoRegE = 0; JumpD = 1; PCSrcD = 0; #1;
    total++; if ({StallD, FlushD} !== 2'b01) $display("FAIL nolw_jump got %b want 01", {StallD, FlushD}); else passed++;
    clear_inputs();
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchD = 1; RegWriteE = 1; WriteRegE = 5; RtD = 5; RsD = 3; #1;
    total++; if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL br_stall got %b want 111", {StallF, StallD, FlushE}); else passed++;
    next_cycle();
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 5; #1;
    total++; if (StallD !== 1'b0) $display("FAIL br_release got %b want 0", StallD); else passed++;
    total++; if ({ForwardAD, ForwardBD} !== 2'b01) $display("FAIL br_fwdbd got %b want 01", {ForwardAD, ForwardBD}); else passed++;
    MemtoRegM = 1; #1;
    total++; if (StallD !== 1'b1) $display("FAIL br_loadm got %b want 1", StallD); else passed++;
    clear_inputs();
  endtask

  task automatic run_muldiv(input logic div, input int n);
    clear_inputs();
    HiLoUseD = 1; MulDivStartE = 1; DivE = div; #1;
    total++; if ({StallD, MulDivBusy} !== 2'b10) $display("FAIL md_start div=%0b got %b want 10", div, {StallD, MulDivBusy}); else passed++;
    for (int i = 1; i <= n; i++) begin
      next_cycle();
      MulDivStartE = 0; DivE = 0; #1;
      total++;
      if ({MulDivBusy, HiLoWe, StallD} !== 3'b101)
        $display("FAIL md_busy div=%0b cyc=%0d got %b want 101", div, i, {MulDivBusy, HiLoWe, StallD});
      else passed++;
    end
    next_cycle();
    total++; if ({MulDivBusy, HiLoWe, StallD} !== 3'b010) $display("FAIL md_done div=%0b got %b want 010", div, {MulDivBusy, HiLoWe, StallD}); else passed++;
    next_cycle();
    total++; if ({MulDivBusy, HiLoWe} !== 2'b00) $display("FAIL md_idle div=%0b got %b want 00", div, {MulDivBusy, HiLoWe}); else passed++;
    clear_inputs();
  endtask

  task automatic test_muldiv();
    run_muldiv(1'b0, 4);
    run_muldiv(1'b1, 32);
  endtask

  task automatic test_rst_abort();
    logic seen_we;
    clear_inputs();
    HiLoUseD = 1; MulDivStartE = 1; DivE = 1;
    next_cycle();
    MulDivStartE = 0; DivE = 0;
    for (int i = 2; i <= 10; i++) next_cycle();
    total++; if (MulDivBusy !== 1'b1) $display("FAIL rst_pre_busy got %b want 1", MulDivBusy); else passed++;
    rst = 1; RegWriteM = 1; WriteRegM = 8; RsE = 8; #1;
    total++; if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) $display("FAIL rst_ovr got %b want 1100", {FlushD, FlushE, StallF, StallD}); else passed++;
    total++; if (ForwardAE !== 2'b00) $display("FAIL rst_fwd got %b want 00", ForwardAE); else passed++;
    next_cycle();
    rst = 0; clear_inputs(); #1;
    total++; if ({MulDivBusy, HiLoWe} !== 2'b00) $display("FAIL rst_abort got %b want 00", {MulDivBusy, HiLoWe}); else passed++;
    seen_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (HiLoWe !== 1'b0 || MulDivBusy !== 1'b0) seen_we = 1'b1;
    end
    total++; if (seen_we !== 1'b0) $display("FAIL rst_no_we got %b want 0", seen_we); else passed++;
    MulDivStartE = 1;
    next_cycle();
    MulDivStartE = 0; #1;
    total++; if (MulDivBusy !== 1'b1) $display("FAIL rst_resume got %b want 1", MulDivBusy); else passed++;
    for (int i = 0; i < 6; i++) next_cycle();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    MulDivStartE = 1;
    next_cycle();
    MulDivStartE = 0;
    for (int i = 2; i <= 5; i++) next_cycle();
    total++; if (HiLoWe !== 1'b1) $display("FAIL b2b_done1 got %b want 1", HiLoWe); else passed++;
    MulDivStartE = 1; DivE = 0;
    next_cycle();
    MulDivStartE = 0; #1;
    total++; if (MulDivBusy !== 1'b1) $display("FAIL b2b_reenter got %b want 1", MulDivBusy); else passed++;
    // a divide start while busy must not extend the multiply
    MulDivStartE = 1; DivE = 1;
    next_cycle();
    MulDivStartE = 0; DivE = 0;
    next_cycle(); next_cycle();
    total++; if ({MulDivBusy, HiLoWe} !== 2'b10) $display("FAIL b2b_last_busy got %b want 10", {MulDivBusy, HiLoWe}); else passed++;
    next_cycle();
    total++; if ({MulDivBusy, HiLoWe} !== 2'b01) $display("FAIL b2b_done2 got %b want 01", {MulDivBusy, HiLoWe}); else passed++;
    next_cycle();
    total++; if ({MulDivBusy, HiLoWe} !== 2'b00) $display("FAIL b2b_idle got %b want 00", {MulDivBusy, HiLoWe}); else passed++;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forward();
    test_lwstall();
    test_branch();
    test_muldiv();
    test_rst_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  MULT_CYCLES, 4, execute-stage cycles for MULT/MULTU.
  DIV_CYCLES, 32, execute-stage cycles for DIV/DIVU.
  CNT_W, 6, latency counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on its rising edge.
  rst  in  1  reset; synchronous, active-high.
  RsD, RtD  in  5  source registers of the decode-stage instruction.
  RsE, RtE  in  5  source registers of the execute-stage instruction.
  WriteRegE, WriteRegM, WriteRegW  in  5  destination registers per stage.
  RegWriteE, RegWriteM, RegWriteW  in  1  register write enables per stage.
  MemtoRegE, MemtoRegM  in  1  load in E / M.
  BranchD, JumpD, PCSrcD  in  1  branch in D, jump in D, branch taken.
  MulDivStartE  in  1  mult/div instruction in E (1-cycle pulse).
  DivE  in  1  with MulDivStartE: 1 = divide, 0 = multiply.
  HiLoUseD  in  1  D instruction reads HI/LO or is mult/div.
  StallF, StallD  out  1  hold PC and IF/ID; drives pipeline-register enable as its inverse.
  FlushD, FlushE  out  1  clear IF/ID and ID/EX; drives pipeline-register CLR.
  ForwardAD, ForwardBD  out  1  forward ALUOutM into the D-stage comparator.
  ForwardAE, ForwardBE  out  2  E-stage operand select.
  MulDivBusy  out  1  registered; unit occupied.
  HiLoWe  out  1  registered 1-cycle pulse; write HI/LO.

Function
REQ-003 SHALL treat any match against register 0 as no match, for all forwarding and stall terms.
REQ-004 ForwardAE SHALL be combinational:
  2'b10 if RegWriteM && WriteRegM==RsE;
  else 2'b01 if RegWriteW && WriteRegW==RsE;
  else 2'b00.
  ForwardBE is identical using RtE. M has priority over W.
REQ-005 ForwardAD SHALL be RegWriteM && WriteRegM==RsD; ForwardBD the same using RtD.
REQ-006 lwstall SHALL be MemtoRegE && (RtE==RsD || RtE==RtD).
REQ-007 branchstall SHALL be BranchD && ((RegWriteE && WriteRegE ∈ {RsD,RtD}) || (MemtoRegM && WriteRegM ∈ {RsD,RtD})).
REQ-008 mdstall SHALL be HiLoUseD && (state==BUSY || MulDivStartE).
REQ-009 StallF = StallD = FlushE SHALL be lwstall | branchstall | mdstall.
REQ-010 FlushD SHALL be (PCSrcD | JumpD) & ~StallD, so a stalled branch is not flushed early.
REQ-011 FSM states SHALL be IDLE, BUSY, DONE, with these transitions:
  IDLE --MulDivStartE--> BUSY; counter loads (DivE ? DIV_CYCLES : MULT_CYCLES) - 1.
  BUSY: counter decrements each cycle; when counter==0 --> DONE.
  DONE --> IDLE, or --> BUSY if MulDivStartE is asserted (counter reloads as above).
REQ-012 MulDivBusy SHALL be 1 exactly in BUSY. HiLoWe SHALL be 1 exactly in DONE, i.e. one cycle after the last busy cycle.
REQ-013 Total latency from the MulDivStartE cycle to the HiLoWe cycle SHALL be N+1 clocks, where N is the selected latency.
REQ-014 MulDivStartE while in BUSY SHALL be ignored; the count and operation type are not changed.
REQ-015 MULT_CYCLES=1 SHALL go IDLE -> BUSY(1 cycle) -> DONE.
REQ-016 The combinational outputs SHALL not depend on the clock level; only the FSM, counter, MulDivBusy and HiLoWe are registered.

Reset
REQ-017 While rst=1 at a rising edge: state<=IDLE, counter<=0, MulDivBusy<=0, HiLoWe<=0.
REQ-018 While rst=1: StallF=StallD=0, FlushD=FlushE=1, Forward*=0, overriding all hazard terms.
REQ-019 rst asserted during BUSY SHALL abort the operation with no HiLoWe pulse; operation resumes from IDLE the cycle after rst deasserts.

Verification
REQ-020 Bench SHALL cover:
  (a) RegWriteM=1, WriteRegM=8, RsE=8, RegWriteW=1, WriteRegW=8 -> ForwardAE=2'b10; set WriteRegM=0, RsE=0 -> ForwardAE=2'b00.
  (b) MemtoRegE=1, RtE=9, RsD=9 -> StallF=StallD=FlushE=1, FlushD=0 even with PCSrcD=1.
  (c) BranchD=1, RegWriteE=1, WriteRegE=5, RtD=5 -> stall for 1 cycle; ForwardBD=1 next cycle when WriteRegM=5.
  (d) MulDivStartE=1, DivE=0, then HiLoUseD=1 -> MulDivBusy high for 4 cycles, HiLoWe high in cycle 5, stall drops in the DONE cycle; repeat with DivE=1 -> 32 busy cycles.
  (e) rst pulsed in BUSY cycle 10 of a divide -> no HiLoWe, MulDivBusy=0 after the edge, FlushD=FlushE=1 during rst.
  (f) Back-to-back MulDivStartE in the DONE cycle -> re-enters BUSY with no IDLE cycle; MulDivStartE in BUSY -> count unchanged.
